fas_frame_sched: RTL
====================

Name: fas_frame_sched

Overview:
- Frame scheduler between the FIR filter and the 16-point FFT engine of the frequency analysis system.
- Packs the FIR output stream into 16-sample frames held in a ping-pong (two-bank) buffer.
- Starts the FFT on each full frame, then starts the peak-frequency analysis stage.
- Counts frames and raises `done` after the last frame's analysis completes.

Parameters:
- DW, 16, sample width (FIR output, 8 integer + 8 fraction bits).
- NPT, 16, samples per frame (FFT size).
- AW, 4, log2(NPT).
- NUM_FRAMES, 64, frames per run (1024 samples).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- fir_d  in  DW  FIR output sample.
- fir_valid  in  1  `fir_d` is valid this cycle.
- fft_start  out  1  one-cycle pulse: frame in read bank is ready for the FFT.
- fft_rd_addr  in  AW  FFT engine sample read index.
- fft_rd_data  out  DW  sample `rd_bank[fft_rd_addr]`, registered, 1-cycle latency.
- fft_done  in  1  one-cycle pulse: FFT finished reading and computing the frame.
- ana_start  out  1  one-cycle pulse: FFT outputs are valid for analysis.
- ana_done  in  1  one-cycle pulse: analysis (`freq`) complete.
- frame_cnt  out  7  frames fully analysed.
- overflow  out  1  sticky: a sample was dropped.
- done  out  1  all NUM_FRAMES analysed; held until reset.

Behaviour:
- Reset (async):
  - Outputs: `fft_start`, `ana_start`, `overflow`, `done` = 0; `frame_cnt` = 0; `fft_rd_data` = 0.
  - Internal: `wr_bank` = 0, `rd_bank` = 0, `wr_idx` = 0, `full[1:0]` = 0, FSM = S_IDLE.
  - Buffer contents are not reset.
  - Reset mid-frame discards all partial and full frames.
- Write side:
  - On `fir_valid`, with `full[wr_bank]` == 0 and `done` == 0: write `fir_d` to `bank[wr_bank][wr_idx]`, then increment `wr_idx`.
  - When `wr_idx` == NPT-1 and a write occurs: set `full[wr_bank]`, toggle `wr_bank`, set `wr_idx` = 0.
  - On `fir_valid` with `full[wr_bank]` == 1: drop the sample, set `overflow` = 1; `wr_idx` is unchanged.
  - `fir_valid` after `done`: ignored; `overflow` is not set.
- Read side:
  - `fft_rd_data` <= `bank[rd_bank][fft_rd_addr]` every cycle.
- FSM:
  - S_IDLE: if `full[rd_bank]`, then `fft_start` <= 1 for one cycle -> S_FFT.
  - S_FFT: wait for `fft_done`. On it: clear `full[rd_bank]`, toggle `rd_bank`, `ana_start` <= 1 for one cycle -> S_ANA.
  - S_ANA: wait for `ana_done`. On it: `frame_cnt` += 1. If new `frame_cnt` == NUM_FRAMES -> S_DONE, else -> S_IDLE.
  - S_DONE: `done` = 1, terminal until reset.
- Latency:
  - Last sample of a frame written at edge t: `full` is visible at t+1, `fft_start` is high in cycle t+2 when the FSM is idle.
  - `fft_done` at edge t: `ana_start` high in cycle t+1.
- Simultaneous events:
  - Clearing `full[rd_bank]` and a write-side drop on the same bank in the same cycle: the sample is still dropped (decision made on pre-edge state); `overflow` is set.
  - Setting `full` on one bank and clearing it on the other in the same cycle: both take effect.
- Spurious pulses: `fft_done` outside S_FFT and `ana_done` outside S_ANA are ignored.
- Sustained throughput: one sample per cycle with no overflow, provided FFT plus analysis finish within NPT cycles.
- Width: `frame_cnt` is 7 bits and saturates naturally at NUM_FRAMES = 64 (no wrap inside a run).

Decomposition:
- Package `fas_pkg`:
  - Constants DW, NPT, AW, NUM_FRAMES.
  - FSM state enum {S_IDLE, S_FFT, S_ANA, S_DONE}.
- Sub-module `fas_pingpong_buf`: two NPT×DW banks, write port (`wr_bank`, `wr_idx`, `we`, data), registered read port (`rd_bank`, addr).
- The FSM and counters live in the top.

Test Plan:
- Reset, then stream 16 samples 0x0100..0x010F on consecutive cycles -> one `fft_start` pulse 2 cycles after the 16th write. Reading addr 0..15 returns 0x0100..0x010F, each 1 cycle after its address.
- Full run: 1024 samples, FFT responding in 10 cycles and analysis in 3 cycles -> 64 `fft_start` and 64 `ana_start` pulses, `frame_cnt` = 64, `done` = 1, `overflow` = 0.
- Back-pressure: hold `fft_done` low, stream 48 samples -> samples 33..48 dropped and `overflow` = 1. Bank 0 keeps samples 1..16, bank 1 keeps 17..32.
- Release after the stall: pulse `fft_done` -> `ana_start` next cycle. After `ana_done`, a second `fft_start` reads bank 1 with data 17..32.
- Async reset asserted mid-frame (`wr_idx` = 7, FSM in S_FFT) -> all outputs 0 immediately. The next 16 samples form frame 0 in bank 0.
- Spurious `ana_done` in S_IDLE and `fft_done` in S_ANA -> no state change and `frame_cnt` unchanged. `fir_valid` after `done` -> no writes and `overflow` stays 0.

Source files
------------

// File: rtl/fas_pkg.sv
// Shared constants and FSM state type for the frame scheduler between the
// FIR filter and the 16-point FFT engine.
package fas_pkg;
  localparam int DW         = 16;
  localparam int NPT        = 16;
  localparam int AW         = 4;
  localparam int NUM_FRAMES = 64;
  localparam int CNTW       = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FFT,
    S_ANA,
    S_DONE
  } state_t;
endpackage

// File: rtl/fas_pingpong_buf.sv
// Two-bank sample buffer: one bank fills from the FIR while the other is read
// by the FFT engine through a registered, 1-cycle-latency read port.
module fas_pingpong_buf
  import fas_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic          wr_bank_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_bank_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o
);
  // Bank number is the MSB of the flat address; storage is deliberately unreset.
  logic [DW-1:0] mem_q [2*NPT];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[{wr_bank_i, wr_idx_i}] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[{rd_bank_i, rd_addr_i}];
    end
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/fas_frame_sched.sv
// Packs FIR samples into ping-pong frames, launches the FFT on each full frame,
// then the analysis stage, and counts frames until the run is complete.
module fas_frame_sched
  import fas_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   fir_d,
  input  logic            fir_valid,
  output logic            fft_start,
  input  logic [AW-1:0]   fft_rd_addr,
  output logic [DW-1:0]   fft_rd_data,
  input  logic            fft_done,
  output logic            ana_start,
  input  logic            ana_done,
  output logic [CNTW-1:0] frame_cnt,
  output logic            overflow,
  output logic            done
);
  state_t          state_q;
  logic            wr_bank_q;
  logic            rd_bank_q;
  logic [AW-1:0]   wr_idx_q;
  logic [1:0]      full_q;
  logic [1:0]      full_d;
  logic            fft_start_q;
  logic            ana_start_q;
  logic            overflow_q;
  logic            done_q;
  logic [CNTW-1:0] frame_cnt_q;

  logic accept;
  logic drop;
  logic frame_last;
  logic release_bank;

  // Accept/drop is decided on pre-edge full flags, so a bank freed this cycle
  // still drops the sample offered in the same cycle.
  assign accept       = fir_valid && !done_q && !full_q[wr_bank_q];
  assign drop         = fir_valid && !done_q &&  full_q[wr_bank_q];
  assign frame_last   = accept && (wr_idx_q == AW'(NPT - 1));
  assign release_bank = (state_q == S_FFT) && fft_done;

  always_comb begin
    full_d = full_q;
    if (release_bank) full_d[rd_bank_q] = 1'b0;
    if (frame_last)   full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      full_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      full_q <= full_d;
      if (accept) begin
        wr_idx_q <= frame_last ? '0 : wr_idx_q + AW'(1);
        if (frame_last) wr_bank_q <= ~wr_bank_q;
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rd_bank_q   <= 1'b0;
      fft_start_q <= 1'b0;
      ana_start_q <= 1'b0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      fft_start_q <= 1'b0;
      ana_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (full_q[rd_bank_q]) begin
            fft_start_q <= 1'b1;
            state_q     <= S_FFT;
          end
        end
        S_FFT: begin
          if (fft_done) begin
            rd_bank_q   <= ~rd_bank_q;
            ana_start_q <= 1'b1;
            state_q     <= S_ANA;
          end
        end
        S_ANA: begin
          if (ana_done) begin
            frame_cnt_q <= frame_cnt_q + CNTW'(1);
            if (frame_cnt_q == CNTW'(NUM_FRAMES - 1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_DONE:  done_q  <= 1'b1;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  fas_pingpong_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .we_i      (accept),
    .wr_bank_i (wr_bank_q),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (fir_d),
    .rd_bank_i (rd_bank_q),
    .rd_addr_i (fft_rd_addr),
    .rd_data_o (fft_rd_data)
  );

  assign fft_start = fft_start_q;
  assign ana_start = ana_start_q;
  assign frame_cnt = frame_cnt_q;
  assign overflow  = overflow_q;
  assign done      = done_q;
endmodule
